// File: rtl/prco_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   REG_WIDTH        : datapath / address width
//   DEFAULT_RESET_PC : first fetch address after reset
//   CNT_W            : width of the prefetch buffer occupancy count
//   fetch_state_e    : fetch FSM states
//   fetch_entry_t    : one buffered word {pc, instr}
package prco_fetch_pkg;

  localparam int unsigned REG_WIDTH = 16;
  localparam int unsigned CNT_W     = 2;

  localparam logic [REG_WIDTH-1:0] DEFAULT_RESET_PC = 16'h0000;

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [REG_WIDTH-1:0] pc;
    logic [REG_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/prco_fetch_buf.sv
// Two-entry in-order prefetch buffer; entry 0 is always the head.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_push, i_din  : append an entry (ignored when full without a pop)
//   i_pop          : drop the head entry
//   i_flush        : empty the buffer; overrides push and pop
//   o_count        : number of valid entries
//   o_head         : head entry (meaningful when o_count != 0)
module prco_fetch_buf
  import prco_fetch_pkg::*;
#(
  parameter int unsigned P_DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  fetch_entry_t     i_din,
  output logic [CNT_W-1:0] o_count,
  output fetch_entry_t     o_head
);

  fetch_entry_t     ent0_q, ent0_d;
  fetch_entry_t     ent1_q, ent1_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_c;

  assign full_c  = (count_q == CNT_W'(P_DEPTH));
  assign o_count = count_q;
  assign o_head  = ent0_q;

  // Next-state: shift toward the head on pop, fill the first free slot on push.
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    if (i_flush) begin
      count_d = '0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (!full_c) begin
            if (count_q == '0) ent0_d = i_din;
            else               ent1_d = i_din;
            count_d = count_q + CNT_W'(1);
          end
        end
        2'b01: begin
          if (count_q != '0) begin
            ent0_d  = ent1_q;
            count_d = count_q - CNT_W'(1);
          end
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever remains.
          if (count_q <= CNT_W'(1)) begin
            ent0_d = i_din;
          end else begin
            ent0_d = ent1_q;
            ent1_d = i_din;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= '0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/prco_fetch.sv
// Instruction fetch: boot FSM, fetch PC, and push/pop/branch control around
// a two-entry prefetch buffer feeding decode.
//   i_clk, i_reset            : clock, asynchronous active-high reset
//   q_mem_addr, i_mem_douta   : local-memory read port (combinational read)
//   i_mem_grant               : fetch owns the memory port this cycle
//   i_branch_en, i_branch_pc  : one-cycle redirect
//   q_instr_valid/_instr/_pc  : word presented to decode
//   i_instr_ready             : decode accepts the word
module prco_fetch
  import prco_fetch_pkg::*;
#(
  parameter logic [REG_WIDTH-1:0] P_RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned          P_BUF_DEPTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  output logic [REG_WIDTH-1:0] q_mem_addr,
  input  logic [REG_WIDTH-1:0] i_mem_douta,
  input  logic                 i_mem_grant,
  input  logic                 i_branch_en,
  input  logic [REG_WIDTH-1:0] i_branch_pc,
  output logic                 q_instr_valid,
  input  logic                 i_instr_ready,
  output logic [REG_WIDTH-1:0] q_instr,
  output logic [REG_WIDTH-1:0] q_instr_pc
);

  fetch_state_e         state_q, state_d;
  logic [REG_WIDTH-1:0] pc_q, pc_d;
  logic                 push_c, pop_c, full_c;
  logic [CNT_W-1:0]     count;
  fetch_entry_t         head;
  fetch_entry_t         din;

  assign full_c        = (count == CNT_W'(P_BUF_DEPTH));
  assign q_instr_valid = (count != '0);
  assign q_instr       = head.instr;
  assign q_instr_pc    = head.pc;
  assign q_mem_addr    = pc_q;
  assign din           = '{pc: pc_q, instr: i_mem_douta};

  // Branch dominates: it blocks both push and pop and flushes the buffer.
  always_comb begin
    pop_c   = q_instr_valid && i_instr_ready && !i_branch_en;
    push_c  = (state_q == ST_RUN) && i_mem_grant && !i_branch_en
              && (!full_c || pop_c);
    state_d = ST_RUN;
    pc_d    = pc_q;
    if (i_branch_en)  pc_d = i_branch_pc;
    else if (push_c)  pc_d = pc_q + REG_WIDTH'(1);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_BOOT;
      pc_q    <= P_RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  prco_fetch_buf #(
    .P_DEPTH (P_BUF_DEPTH)
  ) u_buf (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (push_c),
    .i_pop   (pop_c),
    .i_flush (i_branch_en),
    .i_din   (din),
    .o_count (count),
    .o_head  (head)
  );

endmodule

// File: tb/tb_prco_fetch.sv
// Scoreboard bench for prco_fetch: the driver predicts fetched words into a
// queue, the monitor compares decode-side outputs against the queue head.
module tb_prco_fetch;

  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [15:0] q_mem_addr;
  logic [15:0] i_mem_douta;
  logic        i_mem_grant = 1'b0;
  logic        i_branch_en = 1'b0;
  logic [15:0] i_branch_pc = 16'h0000;
  logic        q_instr_valid;
  logic        i_instr_ready = 1'b0;
  logic [15:0] q_instr;
  logic [15:0] q_instr_pc;

  logic [15:0] mem [0:65535];
  assign i_mem_douta = mem[q_mem_addr];

  // Reference model: fetch PC, boot flag, and the ordered words in flight.
  logic [31:0] sb [$];
  logic [15:0] m_pc = RST_PC;
  logic        m_boot = 1'b1;
  logic        chk_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  prco_fetch #(
    .P_RESET_PC  (RST_PC),
    .P_BUF_DEPTH (2)
  ) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .q_mem_addr    (q_mem_addr),
    .i_mem_douta   (i_mem_douta),
    .i_mem_grant   (i_mem_grant),
    .i_branch_en   (i_branch_en),
    .i_branch_pc   (i_branch_pc),
    .q_instr_valid (q_instr_valid),
    .i_instr_ready (i_instr_ready),
    .q_instr       (q_instr),
    .q_instr_pc    (q_instr_pc)
  );

  initial forever #5 clk = ~clk;

  // Monitor: sample after inputs settle, compare against the model and
  // retire the head when decode accepts it.
  initial forever begin
    @(negedge clk);
    #1;
    if (chk_en && !i_reset) begin
      n_checks++;
      if (q_instr_valid !== (sb.size() != 0)) begin
        n_fail++;
        $display("FAIL valid: got %b want %b (t=%0t)", q_instr_valid, sb.size() != 0, $time);
      end
      n_checks++;
      if (q_mem_addr !== m_pc) begin
        n_fail++;
        $display("FAIL mem_addr: got %h want %h (t=%0t)", q_mem_addr, m_pc, $time);
      end
      if (q_instr_valid && sb.size() != 0) begin
        n_checks++;
        if ({q_instr_pc, q_instr} !== sb[0]) begin
          n_fail++;
          $display("FAIL head pc/instr: got %h/%h want %h/%h (t=%0t)",
                   q_instr_pc, q_instr, sb[0][31:16], sb[0][15:0], $time);
        end
        if (i_instr_ready && !i_branch_en) void'(sb.pop_front());
      end
    end
  end

  // One clock of stimulus; the model is updated at the edge it describes.
  task automatic cyc(input logic g, input logic r, input logic b, input logic [15:0] bpc);
    int  n;
    logic pop, push;
    @(negedge clk);
    i_mem_grant   = g;
    i_instr_ready = r;
    i_branch_en   = b;
    i_branch_pc   = bpc;
    n    = sb.size();
    pop  = (n > 0) && r && !b;
    push = !m_boot && g && !b && ((n < 2) || pop);
    @(posedge clk);
    if (b) begin
      sb.delete();
      m_pc = bpc;
    end else if (push) begin
      sb.push_back({m_pc, mem[m_pc]});
      m_pc = m_pc + 16'd1;
    end
    m_boot = 1'b0;
  endtask

  // Held reset released 2 time units after an edge, so the next edge is boot.
  task automatic do_reset();
    chk_en = 1'b0;
    i_reset = 1'b1;
    i_branch_en = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    i_reset = 1'b0;
    sb.delete();
    m_pc   = RST_PC;
    m_boot = 1'b1;
    chk_en = 1'b1;
  endtask

  // Reset pulse entirely between clock edges; the following edge is boot.
  task automatic async_rst();
    @(negedge clk);
    i_mem_grant   = 1'b1;
    i_instr_ready = 1'b0;
    i_branch_en   = 1'b0;
    #2 i_reset = 1'b1;
    #1;
    n_checks++;
    if (q_instr_valid !== 1'b0 || q_mem_addr !== RST_PC || q_instr !== 16'h0000 || q_instr_pc !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b addr=%h instr=%h pc=%h want v=0 addr=%h instr=0000 pc=0000",
               q_instr_valid, q_mem_addr, q_instr, q_instr_pc, RST_PC);
    end
    #1 i_reset = 1'b0;
    sb.delete();
    m_pc   = RST_PC;
    m_boot = 1'b1;
    @(posedge clk);
    m_boot = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h20ab;
    mem[1] = 16'h21cd;
    mem[2] = 16'h0000;
    mem[3] = 16'h22ef;

    // Reset and boot stream.
    do_reset();
    repeat (6) cyc(1'b1, 1'b1, 1'b0, 16'h0000);

    // Backpressure then drain.
    do_reset();
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (6) cyc(1'b1, 1'b1, 1'b0, 16'h0000);

    // Grant loss mid-stream.
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 16'h0000);
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 16'h0000);

    // Branch while full with ready=1.
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    cyc(1'b1, 1'b1, 1'b1, 16'h0080);
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 16'h0000);

    // PC wrap.
    cyc(1'b1, 1'b1, 1'b1, 16'hFFFF);
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 16'h0000);

    // Asynchronous reset with one word buffered.
    cyc(1'b1, 1'b1, 1'b1, 16'h0040);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000);
    async_rst();
    repeat (6) cyc(1'b1, 1'b1, 1'b0, 16'h0000);

    // Branch during boot.
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 16'h1234);
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 16'h0000);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_rst();
      end else begin
        cyc(1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom));
      end
    end

    @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
